// File: rtl/vdp_vram_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vdp_vram_slot_arbiter
// Purpose  : Time-slot arbiter for the VDP VRAM port. A free-running slot
//            counter uses a fixed schedule:
//              slots 0..L-1    map fetches, one per scroll layer
//              slots L..2L-1   tile fetches, one per scroll layer
//              slot  2L        sprite row fetch
//              slot  SLOTS-1   one host write, taken from a small FIFO
//              other slots     idle, with address 0
//            The affine engine can take the bus on any cycle. When it does,
//            that cycle's fetch strobe or host write is dropped.
// Ports    : clk / reset_n         clock, asynchronous active-low reset
//            line_start_i          restart slot sequence (s=0 next cycle)
//            affine_active_i/
//            affine_address_i      affine bus override
//            map_address_i,
//            tile_address_i        per-layer fetch addresses, ADDR_W each
//            sprite_address_i      sprite fetch address
//            host_*_i / host_ready_o  host write queue handshake + payload
//            vram_*_o              registered VRAM bus
//            map_load_o, char_load_o, sprite_data_valid_o
//                                  fetch-data strobes, 2 cycles after slot
//            host_write_done_o     pulses when a host write is committed
//            fifo_empty_o          host queue empty
// Revision : 1.0 - initial release
// ============================================================================
module vdp_vram_slot_arbiter #(
  parameter int LAYERS     = 4,
  parameter int SLOTS      = 16,
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     line_start_i,
  input  logic                     affine_active_i,
  input  logic [ADDR_W-1:0]        affine_address_i,
  input  logic [LAYERS*ADDR_W-1:0] map_address_i,
  input  logic [LAYERS*ADDR_W-1:0] tile_address_i,
  input  logic [ADDR_W-1:0]        sprite_address_i,
  input  logic                     host_valid_i,
  output logic                     host_ready_o,
  input  logic [ADDR_W-1:0]        host_address_i,
  input  logic [DATA_W-1:0]        host_data_i,
  input  logic [1:0]               host_byte_mask_i,
  output logic [ADDR_W-1:0]        vram_address_o,
  output logic [DATA_W-1:0]        vram_write_data_o,
  output logic [1:0]               vram_we_o,
  output logic [LAYERS-1:0]        map_load_o,
  output logic [LAYERS-1:0]        char_load_o,
  output logic                     sprite_data_valid_o,
  output logic                     host_write_done_o,
  output logic                     fifo_empty_o
);

  localparam int SW = $clog2(SLOTS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [SW-1:0]     s_q, s_d;
  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [1:0]        fifo_mask_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop;

  logic [ADDR_W-1:0] vram_address_q, vram_address_d;
  logic [DATA_W-1:0] vram_write_data_q, vram_write_data_d;
  logic [1:0]        vram_we_q, vram_we_d;

  // Fetch pipeline: stage 1 records which fetch was issued, stage 2 drives
  // the strobe in the cycle when the read data is on the bus.
  logic [LAYERS-1:0] map_hit, char_hit;
  logic [LAYERS-1:0] p1_map_q, p1_char_q;
  logic [LAYERS-1:0] map_load_q, char_load_q;
  logic              spr_hit, p1_spr_q, spr_valid_q, done_q;

  assign host_ready_o = (count_q != CW'(FIFO_DEPTH));
  assign fifo_empty_o = (count_q == '0);
  assign push         = host_valid_i & host_ready_o;

  // line_start only moves the counter; the pipeline and queue are unaffected.
  assign s_d = line_start_i ? '0 : s_q + SW'(1);

  always_comb begin
    vram_address_d    = '0;
    vram_write_data_d = '0;
    vram_we_d         = '0;
    map_hit           = '0;
    char_hit          = '0;
    spr_hit           = 1'b0;
    pop               = 1'b0;
    for (int i = 0; i < LAYERS; i++) begin
      if (s_q == SW'(i)) begin
        vram_address_d = map_address_i[i*ADDR_W +: ADDR_W];
        map_hit[i]     = 1'b1;
      end
      if (s_q == SW'(LAYERS + i)) begin
        vram_address_d = tile_address_i[i*ADDR_W +: ADDR_W];
        char_hit[i]    = 1'b1;
      end
    end
    if (s_q == SW'(2 * LAYERS)) begin
      vram_address_d = sprite_address_i;
      spr_hit        = 1'b1;
    end
    if ((s_q == SW'(SLOTS - 1)) && (count_q != '0)) begin
      vram_address_d    = fifo_addr_q[rd_ptr_q];
      vram_write_data_d = fifo_data_q[rd_ptr_q];
      vram_we_d         = fifo_mask_q[rd_ptr_q];
      pop               = 1'b1;
    end
    // The affine engine wins the bus outright. A blocked host write stays
    // queued, and a blocked fetch produces no strobe.
    if (affine_active_i) begin
      vram_address_d    = affine_address_i;
      vram_write_data_d = '0;
      vram_we_d         = '0;
      map_hit           = '0;
      char_hit          = '0;
      spr_hit           = 1'b0;
      pop               = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Queue storage. It has no reset: only the pointers and count define
  // which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= host_address_i;
      fifo_data_q[wr_ptr_q] <= host_data_i;
      fifo_mask_q[wr_ptr_q] <= host_byte_mask_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s_q               <= '0;
      wr_ptr_q          <= '0;
      rd_ptr_q          <= '0;
      count_q           <= '0;
      vram_address_q    <= '0;
      vram_write_data_q <= '0;
      vram_we_q         <= '0;
      p1_map_q          <= '0;
      p1_char_q         <= '0;
      p1_spr_q          <= 1'b0;
      map_load_q        <= '0;
      char_load_q       <= '0;
      spr_valid_q       <= 1'b0;
      done_q            <= 1'b0;
    end else begin
      s_q               <= s_d;
      count_q           <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      vram_address_q    <= vram_address_d;
      vram_write_data_q <= vram_write_data_d;
      vram_we_q         <= vram_we_d;
      p1_map_q          <= map_hit;
      p1_char_q         <= char_hit;
      p1_spr_q          <= spr_hit;
      map_load_q        <= p1_map_q;
      char_load_q       <= p1_char_q;
      spr_valid_q       <= p1_spr_q;
      done_q            <= pop;
    end
  end

  assign vram_address_o      = vram_address_q;
  assign vram_write_data_o   = vram_write_data_q;
  assign vram_we_o           = vram_we_q;
  assign map_load_o          = map_load_q;
  assign char_load_o         = char_load_q;
  assign sprite_data_valid_o = spr_valid_q;
  assign host_write_done_o   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_vdp_vram_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vdp_vram_slot_arbiter
// Purpose  : Self-checking bench for vdp_vram_slot_arbiter. One instance
//            uses the default parameters. A second instance uses
//            LAYERS=2, SLOTS=8. Both instances share the scalar and host
//            inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vdp_vram_slot_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        line_start = 1'b0;
  logic        affine_active = 1'b0;
  logic [13:0] affine_address = 14'h3FFF;
  logic [55:0] map_address = {14'h0103, 14'h0123, 14'h0101, 14'h0100};
  logic [55:0] tile_address = {14'h0203, 14'h0202, 14'h0201, 14'h0200};
  logic [27:0] map_b = {14'h0501, 14'h0500};
  logic [27:0] tile_b = {14'h0611, 14'h0610};
  logic [13:0] sprite_address = 14'h0300;
  logic        host_valid = 1'b0;
  logic [13:0] host_address = '0;
  logic [15:0] host_data = '0;
  logic [1:0]  host_byte_mask = '0;

  logic        host_ready, sprite_data_valid, host_write_done, fifo_empty;
  logic [13:0] vram_address;
  logic [15:0] vram_write_data;
  logic [1:0]  vram_we;
  logic [3:0]  map_load, char_load;

  logic        b_ready, b_spr, b_done, b_empty;
  logic [13:0] b_addr;
  logic [15:0] b_wdata;
  logic [1:0]  b_we, b_map, b_char;

  vdp_vram_slot_arbiter dut (
    .clk(clk), .reset_n(reset_n), .line_start_i(line_start),
    .affine_active_i(affine_active), .affine_address_i(affine_address),
    .map_address_i(map_address), .tile_address_i(tile_address),
    .sprite_address_i(sprite_address), .host_valid_i(host_valid),
    .host_ready_o(host_ready), .host_address_i(host_address),
    .host_data_i(host_data), .host_byte_mask_i(host_byte_mask),
    .vram_address_o(vram_address), .vram_write_data_o(vram_write_data),
    .vram_we_o(vram_we), .map_load_o(map_load), .char_load_o(char_load),
    .sprite_data_valid_o(sprite_data_valid),
    .host_write_done_o(host_write_done), .fifo_empty_o(fifo_empty)
  );

  vdp_vram_slot_arbiter #(.LAYERS(2), .SLOTS(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .line_start_i(line_start),
    .affine_active_i(affine_active), .affine_address_i(affine_address),
    .map_address_i(map_b), .tile_address_i(tile_b),
    .sprite_address_i(sprite_address), .host_valid_i(host_valid),
    .host_ready_o(b_ready), .host_address_i(host_address),
    .host_data_i(host_data), .host_byte_mask_i(host_byte_mask),
    .vram_address_o(b_addr), .vram_write_data_o(b_wdata),
    .vram_we_o(b_we), .map_load_o(b_map), .char_load_o(b_char),
    .sprite_data_valid_o(b_spr),
    .host_write_done_o(b_done), .fifo_empty_o(b_empty)
  );

  always #5 clk = ~clk;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        hv;
    logic [13:0] ea;
    logic [15:0] ed;
    logic [1:0]  ewe;
    logic [3:0]  eml;
    logic [3:0]  ecl;
    logic        es;
    logic        edone;
    logic        eempty;
  } vec_t;

  vec_t vt [18];

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic set_host(input logic v, input logic [13:0] a, input logic [15:0] d, input logic [1:0] m);
    host_valid     = v;
    host_address   = a;
    host_data      = d;
    host_byte_mask = m;
  endtask

  // After this task returns, the sample point is cycle 1. line_start was
  // high in cycle 0, so s = cycle-1 from cycle 1 on.
  task automatic restart;
    set_host(1'b0, '0, '0, '0);
    line_start    = 1'b0;
    affine_active = 1'b0;
    reset_n       = 1'b0;
    tick;
    tick;
    reset_n    = 1'b1;
    line_start = 1'b1;
    cyc        = 0;
    tick;
    line_start = 1'b0;
  endtask

  logic [13:0] ea_q [5];
  logic [15:0] ed_q [5];
  logic [1:0]  em_q [5];

  initial begin
    int pidx, cidx, acc5, ndone, nwe;
    logic acc;

    // ---------------- reset state ----------------
    #2;
    chk("rst_vram_address", vram_address, 0);
    chk("rst_vram_we", vram_we, 0);
    chk("rst_map_load", map_load, 0);
    chk("rst_host_ready", host_ready, 1);
    chk("rst_fifo_empty", fifo_empty, 1);

    // ---------------- table: one slot period + one push ----------------
    //            hv    addr       data      we     map      char     spr   done  empty
    vt[0]  = '{1'b1, 14'h0100, 16'h0000, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1};
    vt[1]  = '{1'b0, 14'h0100, 16'h0000, 2'b00, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 14'h0101, 16'h0000, 2'b00, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{1'b0, 14'h0123, 16'h0000, 2'b00, 4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 14'h0103, 16'h0000, 2'b00, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0};
    vt[5]  = '{1'b0, 14'h0200, 16'h0000, 2'b00, 4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 14'h0201, 16'h0000, 2'b00, 4'b0000, 4'b0001, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{1'b0, 14'h0202, 16'h0000, 2'b00, 4'b0000, 4'b0010, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{1'b0, 14'h0203, 16'h0000, 2'b00, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0};
    vt[9]  = '{1'b0, 14'h0300, 16'h0000, 2'b00, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b0};
    vt[10] = '{1'b0, 14'h0000, 16'h0000, 2'b00, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0};
    for (int k = 11; k < 16; k++)
      vt[k] = '{1'b0, 14'h0000, 16'h0000, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0};
    vt[16] = '{1'b0, 14'h2000, 16'hBEEF, 2'b11, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1};
    vt[17] = '{1'b0, 14'h0100, 16'h0000, 2'b00, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1};

    restart;
    for (int k = 0; k < 18; k++) begin
      chk("tbl_vram_address", vram_address, vt[k].ea);
      chk("tbl_vram_write_data", vram_write_data, vt[k].ed);
      chk("tbl_vram_we", vram_we, vt[k].ewe);
      chk("tbl_map_load", map_load, vt[k].eml);
      chk("tbl_char_load", char_load, vt[k].ecl);
      chk("tbl_sprite_valid", sprite_data_valid, vt[k].es);
      chk("tbl_write_done", host_write_done, vt[k].edone);
      chk("tbl_fifo_empty", fifo_empty, vt[k].eempty);
      chk("tbl_host_ready", host_ready, 1);
      set_host(vt[k].hv, 14'h2000, 16'hBEEF, 2'b11);
      tick;
    end

    // ---------------- five back-to-back pushes into a 4-deep queue -----
    for (int k = 0; k < 5; k++) begin
      ea_q[k] = 14'h1000 + 14'(k);
      ed_q[k] = 16'hA000 + 16'(k);
    end
    em_q[0] = 2'b11; em_q[1] = 2'b01; em_q[2] = 2'b10; em_q[3] = 2'b11; em_q[4] = 2'b01;
    restart;
    pidx = 0; cidx = 0; acc5 = -1;
    while (cyc <= 90) begin
      if (host_write_done) begin
        if (cidx < 5) begin
          chk("ord_address", vram_address, ea_q[cidx]);
          chk("ord_data", vram_write_data, ed_q[cidx]);
          chk("ord_we", vram_we, em_q[cidx]);
          chk("ord_cycle", cyc, 17 + 16 * cidx);
        end
        cidx++;
      end
      if (cyc == 5)  chk("full_ready_low", host_ready, 0);
      if (cyc == 16) chk("full_ready_still_low", host_ready, 0);
      if (cyc == 17) chk("ready_after_pop", host_ready, 1);
      if (pidx < 5) set_host(1'b1, ea_q[pidx], ed_q[pidx], em_q[pidx]);
      else          set_host(1'b0, '0, '0, '0);
      acc = host_valid && host_ready;
      tick;
      if (acc) begin
        if (pidx == 4) acc5 = cyc - 1;
        pidx++;
      end
    end
    chk("push_count", pidx, 5);
    chk("commit_count", cidx, 5);
    chk("fifth_accept_cycle", acc5, 17);
    chk("drained_empty", fifo_empty, 1);

    // ---------------- affine blocking s=4..15 (cycles 5..16) -----------
    restart;
    ndone = 0;
    while (cyc <= 34) begin
      if (host_write_done) ndone++;
      if (cyc == 5) chk("aff_map_unblocked", map_load, 4'b0100);
      if (cyc >= 7 && cyc <= 18) begin
        chk("aff_char_blocked", char_load, 0);
        chk("aff_sprite_blocked", sprite_data_valid, 0);
      end
      if (cyc >= 6 && cyc <= 17) begin
        chk("aff_we_zero", vram_we, 0);
        chk("aff_address", vram_address, 14'h3FFF);
      end
      if (cyc == 17) begin
        chk("aff_no_commit_17", host_write_done, 0);
        chk("aff_still_queued", fifo_empty, 0);
      end
      if (cyc == 33) begin
        chk("aff_commit_33", host_write_done, 1);
        chk("aff_commit_address", vram_address, 14'h2ABC);
        chk("aff_commit_data", vram_write_data, 16'h1234);
        chk("aff_commit_we", vram_we, 2'b10);
        chk("aff_empty_after", fifo_empty, 1);
      end
      set_host(cyc == 1, 14'h2ABC, 16'h1234, 2'b10);
      affine_active = (cyc >= 5 && cyc <= 16);
      tick;
    end
    affine_active = 1'b0;
    chk("aff_single_commit", ndone, 1);

    // ---------------- mid-period line_start, then async reset ----------
    restart;
    while (cyc <= 8) begin
      if (cyc == 6) begin
        chk("ls_keep_map", map_load, 4'b1000);
        chk("ls_queue_kept", fifo_empty, 0);
      end
      if (cyc == 7) chk("ls_keep_char", char_load, 4'b0001);
      if (cyc == 8) begin
        chk("ls_restart_map", map_load, 4'b0001);
        chk("ls_restart_address", vram_address, 14'h0101);
        chk("ls_restart_queue", host_ready, 1);
      end
      if (cyc < 8) begin
        set_host(cyc <= 3, 14'h3000 + 14'(cyc), 16'h7000 + 16'(cyc), 2'b11);
        line_start = (cyc == 5);
        tick;
      end else begin
        break;
      end
    end
    set_host(1'b0, '0, '0, '0);
    line_start = 1'b0;
    chk("pre_reset_not_empty", fifo_empty, 0);
    reset_n = 1'b0;
    #1;
    chk("arst_vram_address", vram_address, 0);
    chk("arst_vram_data", vram_write_data, 0);
    chk("arst_vram_we", vram_we, 0);
    chk("arst_map_load", map_load, 0);
    chk("arst_char_load", char_load, 0);
    chk("arst_sprite", sprite_data_valid, 0);
    chk("arst_done", host_write_done, 0);
    chk("arst_ready", host_ready, 1);
    chk("arst_empty", fifo_empty, 1);
    tick;
    tick;
    reset_n    = 1'b1;
    line_start = 1'b1;
    cyc = 0;
    tick;
    line_start = 1'b0;
    ndone = 0; nwe = 0;
    for (int k = 0; k < 40; k++) begin
      if (host_write_done) ndone++;
      if (vram_we != 2'b00) nwe++;
      tick;
    end
    chk("no_stale_done", ndone, 0);
    chk("no_stale_we", nwe, 0);

    // ---------------- small config + simultaneous push/pop -------------
    restart;
    while (cyc <= 34) begin
      if (cyc == 5) begin
        chk("b_tile1_address", b_addr, 14'h0611);
        chk("b_char0", b_char, 2'b01);
      end
      if (cyc == 6) chk("b_char1_pulse", b_char, 2'b10);
      if (cyc == 7) chk("b_char_after", b_char, 2'b00);
      if (cyc == 7 || cyc == 8) begin
        chk("b_idle_address", b_addr, 0);
        chk("b_idle_we", b_we, 0);
      end
      if (cyc == 9) begin
        chk("b_host_done", b_done, 1);
        chk("b_host_address", b_addr, 14'h0777);
        chk("b_host_data", b_wdata, 16'h5A5A);
        chk("b_host_we", b_we, 2'b01);
      end
      if (cyc == 17) begin
        chk("b_empty_slot_we", b_we, 0);
        chk("b_empty_slot_done", b_done, 0);
        chk("a_pushpop_done", host_write_done, 1);
        chk("a_pushpop_address", vram_address, 14'h0777);
        chk("a_pushpop_count", fifo_empty, 0);
      end
      if (cyc == 25) begin
        chk("b_second_address", b_addr, 14'h0888);
        chk("b_second_we", b_we, 2'b11);
      end
      if (cyc == 33) begin
        chk("a_second_done", host_write_done, 1);
        chk("a_second_address", vram_address, 14'h0888);
        chk("a_second_data", vram_write_data, 16'hC3C3);
        chk("a_second_empty", fifo_empty, 1);
      end
      if (cyc == 1)       set_host(1'b1, 14'h0777, 16'h5A5A, 2'b01);
      else if (cyc == 16) set_host(1'b1, 14'h0888, 16'hC3C3, 2'b11);
      else                set_host(1'b0, '0, '0, '0);
      tick;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
